scope_trigger_capture: RTL and testbench
========================================

SCOPE_TRIGGER_CAPTURE -- requirements
Module: scope_trigger_capture

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning frame length 2^ADDR_W samples (1024).
REQ-002 SHALL have parameter DATA_W, default 8, meaning sample width.
REQ-003 SHALL have parameter AUTO_TIMEOUT, default 4096, meaning decimated-sample ticks to wait for a trigger before forcing capture in auto mode.
REQ-004 SHALL have one clock, `clk`; reset is asynchronous and active-low, named `rst_n`.
REQ-005 Ports, in order:
  - `clk` in 1: single clock.
  - `rst_n` in 1: async active-low reset.
  - `adc_data` in DATA_W: incoming sample.
  - `adc_valid` in 1: adc_data valid this cycle.
  - `run` in 1: 1 = acquire continuously; 0 = freeze after current frame.
  - `trig_level` in DATA_W: trigger threshold, unsigned.
  - `trig_edge` in 1: 0 = rising, 1 = falling.
  - `trig_mode` in 1: 0 = auto, 1 = normal.
  - `decim` in 8: keep 1 of every decim+1 valid samples.
  - `frame_sync` in 1: display vsync pulse, 1 cycle.
  - `wr_addr` out ADDR_W: buffer write address.
  - `sample_data` out DATA_W: buffer write data.
  - `wr_en` out 1: buffer write strobe.
  - `ram_sel` out 1: ping-pong select; the buffer reads from the bank not being written.
  - `trig_ok` out 1: last completed frame was truly triggered.
  - `busy` out 1: state is not IDLE.

Function
REQ-006 SHALL implement FSM states IDLE, WAIT_TRIG, CAPTURE, DONE.
REQ-007 IDLE -> WAIT_TRIG when run=1; decim is latched on this transition and on DONE -> WAIT_TRIG.
REQ-008 SHALL generate a tick on every adc_valid at which the decimation counter equals latched decim, then clear the counter; decim=0 gives a tick on every valid sample; the counter is cleared on entry to WAIT_TRIG.
REQ-009 On a tick in WAIT_TRIG, the current sample is cur and the previous ticked sample is prev.
  - Rising trigger: prev < trig_level AND cur >= trig_level.
  - Falling trigger: prev > trig_level AND cur <= trig_level.
  - prev is invalid on the first tick after entering WAIT_TRIG, so no trigger can fire on that tick.
REQ-010 In auto mode, a timeout counter counts ticks in WAIT_TRIG; reaching AUTO_TIMEOUT forces a capture as if triggered on that tick, with the trigger flag = 0. In normal mode the state waits indefinitely.
REQ-011 The triggering (or forcing) sample SHALL be written at address 0, and each subsequent tick writes at address+1.
  - Outputs are registered: wr_en, wr_addr and sample_data assert one cycle after the tick.
  - wr_en is high for exactly one cycle per written sample.
REQ-012 After the write to address 2^ADDR_W-1, the FSM SHALL enter DONE; wr_addr wraps to 0; no further writes occur.
REQ-013 In DONE, the first frame_sync SHALL toggle ram_sel on the next cycle and latch trig_ok from the trigger flag.
  - Next state is WAIT_TRIG if run=1, else IDLE.
REQ-014 frame_sync outside DONE SHALL be ignored and not remembered; ram_sel never changes outside DONE, so the displayed bank is never torn.
REQ-015 run deasserted during WAIT_TRIG SHALL return the FSM to IDLE next cycle; run deasserted during CAPTURE SHALL not abort the frame.
REQ-016 frame_sync coincident with the final write SHALL be ignored; the next frame_sync performs the swap.
REQ-017 Changes to trig_level, trig_edge and trig_mode SHALL take effect on the next tick; changes to decim take effect at the next latch point.

Reset
REQ-018 On rst_n low, asynchronously:
  - state = IDLE;
  - wr_addr = 0, sample_data = 0, wr_en = 0;
  - ram_sel = 0, trig_ok = 0, busy = 0;
  - all counters and the prev-valid flag cleared.
REQ-019 Reset asserted mid-capture SHALL abandon the frame; after release no write occurs until run=1 and a new trigger.

Structure
REQ-020 Package scope_pkg SHALL hold the FSM state enum, default ADDR_W/DATA_W, and the edge and mode encodings.
REQ-021 Edge detection (prev register, compare, prev-valid) SHALL be a sub-module scope_trig_detect; decimation, timeout, FSM and write port stay in the top module.

Verification
REQ-022 trig_mode=1, rising, level=128, decim=0, ramp 0..255 repeating -> first wr_en writes data 128 at addr 0; addr 1023 holds 127 (1151 mod 256); then DONE.
REQ-023 Frame complete, frame_sync pulses twice -> ram_sel toggles once, one cycle after the first pulse; trig_ok=1.
REQ-024 trig_mode=0, constant input 50, level=128, AUTO_TIMEOUT=16 -> capture starts on tick 16 of WAIT_TRIG; trig_ok=0 after the swap.
REQ-025 decim=3, falling edge, level=100 -> exactly one wr_en per 4 adc_valid; 1024 writes total; the addr-0 sample is <=100 and the preceding tick sample is >100.
REQ-026 rst_n pulsed low at addr 500 -> all outputs 0 immediately; ram_sel=0; no writes until re-trigger.
REQ-027 run dropped at addr 300 -> capture completes to 1023; swap happens on frame_sync; state becomes IDLE; busy=0.

Source files
------------

// File: rtl/scope_pkg.sv
// scope_pkg: shared FSM state type, default widths and trigger edge/mode encodings
package scope_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 8;
  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;
  localparam logic MODE_AUTO = 1'b0;
  localparam logic MODE_NORMAL = 1'b1;
endpackage

// File: rtl/scope_trig_detect.sv
// scope_trig_detect: level-crossing detector over the decimated sample stream
// ports: clk/rst_n; clr drops the previous-sample history; tick qualifies cur;
//        level/trig_edge select the crossing; fire flags a crossing on this tick
module scope_trig_detect
  import scope_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              tick,
  input  logic [DATA_W-1:0] cur,
  input  logic [DATA_W-1:0] level,
  input  logic              trig_edge,
  output logic              fire
);
  logic [DATA_W-1:0] prev_q, prev_d;
  logic pv_q, pv_d;
  always_comb begin
    prev_d = tick ? cur : prev_q;
    pv_d = clr ? 1'b0 : tick ? 1'b1 : pv_q;
    fire = tick && pv_q && (trig_edge == EDGE_FALL ? (prev_q > level && cur <= level)
                                                   : (prev_q < level && cur >= level));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev_q <= '0;
      pv_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      pv_q <= pv_d;
    end
endmodule

// File: rtl/scope_trigger_capture.sv
// scope_trigger_capture: triggered, decimated frame capture into a ping-pong sample buffer
// ports: clk/rst_n; adc_data/adc_valid sample in; run, trig_level/edge/mode, decim config;
//        frame_sync display vsync; wr_addr/sample_data/wr_en buffer write port;
//        ram_sel displayed bank; trig_ok last frame truly triggered; busy not idle
module scope_trigger_capture
  import scope_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int AUTO_TIMEOUT = 4096
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              run,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic              trig_mode,
  input  logic [7:0]        decim,
  input  logic              frame_sync,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] sample_data,
  output logic              wr_en,
  output logic              ram_sel,
  output logic              trig_ok,
  output logic              busy
);
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LIM = TW'(AUTO_TIMEOUT - 1);
  state_t state_q, state_d;
  logic [7:0] decim_q, decim_d, dcnt_q, dcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [ADDR_W-1:0] acnt_q, acnt_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic flag_q, flag_d, wr_en_q, wr_en_d, ram_sel_q, ram_sel_d, trig_ok_q, trig_ok_d;
  logic active, tick, fire, force_cap, start, swap;
  assign active = state_q == WAIT_TRIG || state_q == CAPTURE;
  assign tick = adc_valid && active && dcnt_q == decim_q;
  // tcnt saturates, so switching normal->auto after a long wait forces on the next tick
  assign force_cap = tick && trig_mode == MODE_AUTO && tcnt_q == T_LIM;
  assign start = state_q == WAIT_TRIG && run && (fire || force_cap);
  // the cycle showing the final write is still DONE, but a sync there must not swap
  assign swap = state_q == DONE && frame_sync && !wr_en_q;
  scope_trig_detect #(.DATA_W(DATA_W)) u_det (
    .clk(clk), .rst_n(rst_n), .clr(state_q != WAIT_TRIG), .tick(tick),
    .cur(adc_data), .level(trig_level), .trig_edge(trig_edge), .fire(fire)
  );
  always_comb begin
    state_d = state_q;
    decim_d = decim_q;
    dcnt_d = (adc_valid && active) ? (tick ? 8'd0 : dcnt_q + 8'd1) : dcnt_q;
    tcnt_d = state_q != WAIT_TRIG ? '0 : (tick && tcnt_q != T_LIM) ? tcnt_q + TW'(1) : tcnt_q;
    acnt_d = start ? ADDR_W'(1) : (state_q == CAPTURE && tick) ? acnt_q + ADDR_W'(1) : acnt_q;
    flag_d = start ? fire : flag_q;
    wr_en_d = start || (state_q == CAPTURE && tick);
    wr_addr_d = wr_en_d ? (start ? '0 : acnt_q) : wr_en_q ? wr_addr_q + ADDR_W'(1) : wr_addr_q;
    sample_d = wr_en_d ? adc_data : sample_q;
    ram_sel_d = ram_sel_q ^ swap;
    trig_ok_d = swap ? flag_q : trig_ok_q;
    unique case (state_q)
      IDLE: if (run) begin
        state_d = WAIT_TRIG;
        decim_d = decim;
        dcnt_d = 8'd0;
      end
      WAIT_TRIG: state_d = !run ? IDLE : start ? CAPTURE : WAIT_TRIG;
      CAPTURE: state_d = (tick && &acnt_q) ? DONE : CAPTURE;
      DONE: if (swap) begin
        state_d = run ? WAIT_TRIG : IDLE;
        decim_d = run ? decim : decim_q;
        dcnt_d = 8'd0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      decim_q <= 8'd0;
      dcnt_q <= 8'd0;
      tcnt_q <= '0;
      acnt_q <= '0;
      flag_q <= 1'b0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      sample_q <= '0;
      ram_sel_q <= 1'b0;
      trig_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      decim_q <= decim_d;
      dcnt_q <= dcnt_d;
      tcnt_q <= tcnt_d;
      acnt_q <= acnt_d;
      flag_q <= flag_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      sample_q <= sample_d;
      ram_sel_q <= ram_sel_d;
      trig_ok_q <= trig_ok_d;
    end
  assign wr_addr = wr_addr_q;
  assign sample_data = sample_q;
  assign wr_en = wr_en_q;
  assign ram_sel = ram_sel_q;
  assign trig_ok = trig_ok_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_scope_trigger_capture.sv
// tb_scope_trigger_capture: scenario table plus random frames checked against a sample-list model
module tb_scope_trigger_capture;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int AT = 16;
  localparam int FRAME = 1 << AW;
  localparam int BUDGET = 20000;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] adc_data = '0, trig_level = '0;
  logic adc_valid = 1'b0, run = 1'b0, trig_edge = 1'b0, trig_mode = 1'b0, frame_sync = 1'b0;
  logic [7:0] decim = 8'd0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] sample_data;
  logic wr_en, ram_sel, trig_ok, busy;
  typedef struct {int decim; bit edg; bit mode; int level; int pat; int drop; bit fsf; int exp_first; int exp_last; bit exp_trig;} row_t;
  typedef struct {int a; int d;} wr_t;
  row_t rows[7];
  wr_t got[$];
  int vq[$], tk[$];
  int n_chk = 0, n_fail = 0;
  bit exp_sel = 1'b0;
  scope_trigger_capture #(.ADDR_W(AW), .DATA_W(DW), .AUTO_TIMEOUT(AT)) dut (
    .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid), .run(run),
    .trig_level(trig_level), .trig_edge(trig_edge), .trig_mode(trig_mode), .decim(decim),
    .frame_sync(frame_sync), .wr_addr(wr_addr), .sample_data(sample_data), .wr_en(wr_en),
    .ram_sel(ram_sel), .trig_ok(trig_ok), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (wr_en === 1'b1) got.push_back('{int'(wr_addr), int'(sample_data)});
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // the frame is the 2^AW ticked samples starting at the first crossing (or the forced tick)
  task automatic model(input row_t r, output int s, output bit f);
    tk.delete();
    for (int k = r.decim; k < vq.size(); k += r.decim + 1) tk.push_back(vq[k]);
    s = -1;
    f = 1'b0;
    for (int i = 0; i < tk.size() && s < 0; i++)
      if (i > 0 && (r.edg ? (tk[i-1] > r.level && tk[i] <= r.level) : (tk[i-1] < r.level && tk[i] >= r.level))) begin
        s = i;
        f = 1'b1;
      end else if (!r.mode && i == AT - 1) s = i;
  endtask
  task automatic scenario(input row_t r);
    int cnt = 0, cyc = 0, s, mism = 0, bad = -1;
    bit mid = 0, fin = 0, f;
    got.delete();
    vq.delete();
    @(posedge clk); #1;
    trig_level = DW'(r.level); trig_edge = r.edg; trig_mode = r.mode; decim = 8'(r.decim);
    run = 1'b1; adc_valid = 1'b0; frame_sync = 1'b0;
    @(posedge clk); #1;
    while (got.size() < FRAME && cyc < BUDGET) begin
      adc_valid = r.pat == 2 ? ($urandom_range(3) != 0) : 1'b1;
      adc_data = r.pat == 0 ? DW'(cnt) : r.pat == 1 ? DW'(50) : DW'($urandom);
      if (adc_valid) begin vq.push_back(int'(adc_data)); cnt++; end
      frame_sync = 1'b0;
      if (!mid && got.size() == 100) begin frame_sync = 1'b1; mid = 1; end
      if (r.fsf && !fin && got.size() == FRAME - 1) begin frame_sync = 1'b1; fin = 1; end
      if (r.drop >= 0 && got.size() >= r.drop) run = 1'b0;
      if (cyc == 3) decim = 8'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    chk("capture_in_budget", 32'(cyc < BUDGET), 1);
    frame_sync = 1'b0;
    run = 1'b0;
    repeat (20) begin
      adc_valid = $urandom_range(1);
      adc_data = DW'($urandom);
      @(posedge clk); #1;
    end
    chk("write_count", got.size(), FRAME);
    model(r, s, f);
    foreach (got[j])
      if (s < 0 || s + j >= tk.size() || got[j].a != j || got[j].d != tk[s + j]) begin
        mism++;
        if (bad < 0) bad = j;
      end
    if (bad >= 0) $display("first bad write index %0d", bad);
    chk("frame_data", mism, 0);
    if (r.exp_first >= 0) begin
      chk("first_sample", got.size() > 0 ? got[0].d : -1, r.exp_first);
      chk("last_sample", got.size() == FRAME ? got[FRAME-1].d : -1, r.exp_last);
    end
    chk("no_swap_yet", ram_sel, exp_sel);
    chk("busy_done", busy, 1);
    frame_sync = 1'b1;
    @(posedge clk); #1;
    frame_sync = 1'b0;
    exp_sel = ~exp_sel;
    chk("swap", ram_sel, exp_sel);
    chk("trig_ok", trig_ok, r.exp_first >= 0 ? r.exp_trig : f);
    repeat (3) @(posedge clk);
    #1 frame_sync = 1'b1;
    @(posedge clk); #1;
    frame_sync = 1'b0;
    @(posedge clk); #1;
    chk("second_sync", ram_sel, exp_sel);
    chk("idle_busy", busy, 0);
  endtask
  initial begin
    int cnt = 0, cyc = 0;
    //              decim edg mode lvl  pat drop fsf first last trig
    rows[0] = '{0, 0, 1, 128, 0, -1, 1, 128, 127, 1};
    rows[1] = '{0, 0, 0, 128, 1, -1, 0, 50, 50, 0};
    rows[2] = '{0, 0, 0, 255, 0, -1, 0, 15, 14, 0};
    rows[3] = '{3, 1, 1, 100, 0, 300, 0, 3, 255, 1};
    for (int i = 4; i < 7; i++)
      rows[i] = '{int'($urandom_range(2)), 1'($urandom), 1'($urandom), int'($urandom_range(32, 223)), 2, -1, 0, -1, -1, 0};
    #12;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_sample", sample_data, 0);
    chk("rst_ram_sel", ram_sel, 0);
    chk("rst_trig_ok", trig_ok, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    foreach (rows[i]) scenario(rows[i]);
    got.delete();
    @(posedge clk); #1;
    trig_level = 8'd128; trig_edge = 1'b0; trig_mode = 1'b1; decim = 8'd0; run = 1'b1;
    while (got.size() < 500 && cyc < BUDGET) begin
      adc_valid = 1'b1;
      adc_data = DW'(cnt);
      cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("sel_before_reset", ram_sel, exp_sel);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_sample", sample_data, 0);
    chk("mid_rst_ram_sel", ram_sel, 0);
    chk("mid_rst_trig_ok", trig_ok, 0);
    chk("mid_rst_busy", busy, 0);
    run = 1'b0;
    @(negedge clk);
    got.delete();
    rst_n = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      adc_data = DW'(cnt);
      cnt++;
    end
    chk("no_write_idle", got.size(), 0);
    run = 1'b1;
    adc_data = 8'd50;
    repeat (100) @(posedge clk);
    #1;
    chk("no_write_untriggered", got.size(), 0);
    chk("busy_waiting", busy, 1);
    run = 1'b0;
    adc_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
